// File: rtl/mtr_drv_pwm_pkg.sv
//  +-------------------------------------------------------------------+
//  | Package   : mtr_drv_pkg                                           |
//  | Purpose   : Shared constants and types for the dual H-bridge PWM  |
//  |             motor driver (mtr_drv_pwm and its channel sub-block). |
//  | Contents  : PWM_W_DEF  default PWM counter width                  |
//  |             SPD_W      width of the signed speed commands         |
//  |             MAG_MAX    largest magnitude at the default width     |
//  |             chan_state_e  per-wheel bridge state                  |
//  | Revision  : 1.0  initial release                                  |
//  +-------------------------------------------------------------------+
`default_nettype none

package mtr_drv_pkg;

  localparam int PWM_W_DEF = 11;
  localparam int SPD_W     = 12;
  localparam int MAG_MAX   = (1 << PWM_W_DEF) - 1;

  // BLANK holds both bridge legs off for one full period on a reversal.
  typedef enum logic [1:0] {
    FWD   = 2'd0,
    REV   = 2'd1,
    BLANK = 2'd2
  } chan_state_e;

endpackage

`default_nettype wire

// File: rtl/mtr_drv_pwm_if.sv
//  +-------------------------------------------------------------------+
//  | Interface : mtr_drv_pwm_if                                        |
//  | Purpose   : Bundles the speed commands, enable and bridge drives  |
//  |             of the motor driver.                                  |
//  | Signals   : lft_spd, rght_spd  signed speed commands (in)         |
//  |             mtr_en             motor enable (in)                  |
//  |             *_fwd_pwm/*_rev_pwm  H-bridge leg drives (out)        |
//  |             prd_sync           end-of-period pulse (out)          |
//  | Modports  : master = command source, slave = driver               |
//  | Revision  : 1.0  initial release                                  |
//  +-------------------------------------------------------------------+
`default_nettype none

interface mtr_drv_pwm_if;
  import mtr_drv_pkg::*;

  logic signed [SPD_W-1:0] lft_spd;
  logic signed [SPD_W-1:0] rght_spd;
  logic                    mtr_en;
  logic                    lft_fwd_pwm;
  logic                    lft_rev_pwm;
  logic                    rght_fwd_pwm;
  logic                    rght_rev_pwm;
  logic                    prd_sync;

  modport master (
    output lft_spd, rght_spd, mtr_en,
    input  lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, prd_sync
  );

  modport slave (
    input  lft_spd, rght_spd, mtr_en,
    output lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, prd_sync
  );

endinterface

`default_nettype wire

// File: rtl/mtr_drv_pwm_chan.sv
//  +-------------------------------------------------------------------+
//  | Module    : mtr_drv_chan                                          |
//  | Purpose   : One wheel channel: sign-magnitude conversion, the     |
//  |             FWD/REV/BLANK reversal FSM, per-period magnitude      |
//  |             latch and the PWM compare driving one H-bridge.       |
//  | Ports     : clk, rst_n    clock / async active-low reset          |
//  |             spd           signed speed command                    |
//  |             mtr_en        enable (low forces zero magnitude)      |
//  |             cnt, bnd      shared counter and boundary strobe      |
//  |             fwd_pwm       forward-leg drive (registered)          |
//  |             rev_pwm       reverse-leg drive (registered)          |
//  | Option    : MTR_DRV_BRAKE_EN - zero magnitude in FWD/REV drives   |
//  |             both legs high (dynamic brake) instead of coasting.   |
//  | Revision  : 1.0  initial release                                  |
//  +-------------------------------------------------------------------+
`default_nettype none

module mtr_drv_chan
  import mtr_drv_pkg::*;
#(
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [SPD_W-1:0] spd,
  input  logic                    mtr_en,
  input  logic [PWM_W-1:0]        cnt,
  input  logic                    bnd,
  output logic                    fwd_pwm,
  output logic                    rev_pwm
);

  localparam int unsigned c_mag_max = (1 << PWM_W) - 1;

  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic             r_tgt;        // direction to enter after BLANK (1 = reverse)
  logic             w_tgt_nxt;
  logic [PWM_W-1:0] r_mag;
  logic [PWM_W-1:0] w_mag_nxt;
  logic             r_fwd;
  logic             r_rev;
  logic             w_fwd_nxt;
  logic             w_rev_nxt;

  logic             w_sgn;
  logic [SPD_W-1:0] w_spd_u;
  logic [SPD_W-1:0] w_abs;
  logic [PWM_W-1:0] w_mag_smp;
  logic             w_on;
  logic             w_brake;

  // Two's complement negate of the most negative code wraps to itself,
  // which read unsigned is exactly its magnitude; the clamp below then
  // saturates it to the largest duty.
  assign w_sgn   = spd[SPD_W-1];
  assign w_spd_u = spd;
  assign w_abs   = w_sgn ? (SPD_W'(0) - w_spd_u) : w_spd_u;

  always_comb begin
    w_mag_smp = '0;
    if (mtr_en) begin
      if (32'(w_abs) > c_mag_max) begin
        w_mag_smp = PWM_W'(c_mag_max);
      end else begin
        w_mag_smp = PWM_W'(w_abs);
      end
    end
  end

  // Next-state logic: decisions are taken only on the boundary edge so a
  // period in progress is never altered.
  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_mag_nxt   = r_mag;
    if (bnd) begin
      unique case (r_state)
        FWD, REV: begin
          if (w_mag_smp == '0) begin
            // A zero command never counts as a reversal.
            w_mag_nxt = '0;
          end else if (w_sgn == (r_state == REV)) begin
            w_mag_nxt = w_mag_smp;
          end else begin
            w_state_nxt = BLANK;
            w_tgt_nxt   = w_sgn;
            w_mag_nxt   = '0;
          end
        end
        BLANK: begin
          if ((w_mag_smp != '0) && (w_sgn != r_tgt)) begin
            // Command flipped again during blanking: blank once more
            // toward the newest direction.
            w_tgt_nxt = w_sgn;
            w_mag_nxt = '0;
          end else begin
            w_state_nxt = r_tgt ? REV : FWD;
            w_mag_nxt   = w_mag_smp;
          end
        end
        default: begin
          w_state_nxt = FWD;
          w_mag_nxt   = '0;
        end
      endcase
    end
  end

  assign w_on = (cnt < r_mag);

`ifdef MTR_DRV_BRAKE_EN
  assign w_brake = (r_state != BLANK) && (r_mag == '0);
`else
  assign w_brake = 1'b0;
`endif

  assign w_fwd_nxt = ((r_state == FWD) && w_on) || w_brake;
  assign w_rev_nxt = ((r_state == REV) && w_on) || w_brake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FWD;
      r_tgt   <= 1'b0;
      r_mag   <= '0;
      r_fwd   <= 1'b0;
      r_rev   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_mag   <= w_mag_nxt;
      r_fwd   <= w_fwd_nxt;
      r_rev   <= w_rev_nxt;
    end
  end

  assign fwd_pwm = r_fwd;
  assign rev_pwm = r_rev;

endmodule

`default_nettype wire

// File: rtl/mtr_drv_pwm.sv
//  +-------------------------------------------------------------------+
//  | Module    : mtr_drv_pwm                                           |
//  | Purpose   : Dual H-bridge PWM driver. Converts the signed left /  |
//  |             right wheel speed commands to glitch-free PWM pairs   |
//  |             with one blanking period on every direction reversal. |
//  | Ports     : clk    system clock                                   |
//  |             rst_n  asynchronous active-low reset                  |
//  |             bus    mtr_drv_pwm_if.slave (commands, enable, leg    |
//  |                    drives, prd_sync)                              |
//  | Params    : PWM_W  counter width, period = 2**PWM_W clocks        |
//  | Option    : MTR_DRV_BRAKE_EN - dynamic brake on zero magnitude    |
//  |             (handled inside mtr_drv_chan).                        |
//  | Revision  : 1.0  initial release                                  |
//  +-------------------------------------------------------------------+
`default_nettype none

module mtr_drv_pwm
  import mtr_drv_pkg::*;
#(
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mtr_drv_pwm_if.slave bus
);

  logic [PWM_W-1:0] r_cnt;
  logic             r_prd_sync;
  logic             w_bnd;

  // Boundary is the last count of the period; both channels sample here.
  assign w_bnd = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_prd_sync <= 1'b0;
    end else begin
      r_cnt      <= r_cnt + PWM_W'(1);
      r_prd_sync <= w_bnd;
    end
  end

  mtr_drv_chan #(
    .PWM_W (PWM_W)
  ) u_lft (
    .clk     (clk),
    .rst_n   (rst_n),
    .spd     (bus.lft_spd),
    .mtr_en  (bus.mtr_en),
    .cnt     (r_cnt),
    .bnd     (w_bnd),
    .fwd_pwm (bus.lft_fwd_pwm),
    .rev_pwm (bus.lft_rev_pwm)
  );

  mtr_drv_chan #(
    .PWM_W (PWM_W)
  ) u_rght (
    .clk     (clk),
    .rst_n   (rst_n),
    .spd     (bus.rght_spd),
    .mtr_en  (bus.mtr_en),
    .cnt     (r_cnt),
    .bnd     (w_bnd),
    .fwd_pwm (bus.rght_fwd_pwm),
    .rev_pwm (bus.rght_rev_pwm)
  );

  assign bus.prd_sync = r_prd_sync;

endmodule

`default_nettype wire

// File: tb/tb_mtr_drv_pwm.sv
//  +-------------------------------------------------------------------+
//  | Module    : tb_mtr_drv_pwm                                        |
//  | Purpose   : Self-checking bench for mtr_drv_pwm: a period-level   |
//  |             model predicts every leg and prd_sync each cycle;     |
//  |             directed scenarios pin high-time counts per period.   |
//  | Revision  : 1.0  initial release                                  |
//  +-------------------------------------------------------------------+
`default_nettype none

module tb_mtr_drv_pwm;

  localparam int PER = 2048;
  localparam int MAX = 2047;
`ifdef MTR_DRV_BRAKE_EN
  localparam int BRK = PER;
`else
  localparam int BRK = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mtr_drv_pwm_if bus ();

  mtr_drv_pwm #(.PWM_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-wheel plan for one output period: which leg, how many high clocks,
  // or a blanking period with the direction to resume afterwards.
  typedef struct packed {
    logic        blank;
    logic        tgt;
    logic        dir;   // 1 = reverse
    logic [11:0] mag;
  } plan_t;

  plan_t pend [2];
  plan_t act  [2];
  int    ecnt;    // counter value during the current cycle
  int    since;   // clocks since reset release

  int acc  [4];
  int last [4];   // high clocks of lft_fwd, lft_rev, rght_fwd, rght_rev in last period

  function automatic int sat_mag(input logic signed [11:0] s, input logic en);
    int v;
    v = s;
    if (!en) return 0;
    if (v < 0) v = -v;
    if (v > MAX) v = MAX;
    return v;
  endfunction

  function automatic plan_t decide(input plan_t cur, input logic signed [11:0] s, input logic en);
    plan_t n;
    int    m;
    logic  neg;
    n   = cur;
    m   = sat_mag(s, en);
    neg = (s < 0);
    if (cur.blank) begin
      if (m != 0 && neg != cur.tgt) begin
        n.tgt = neg;
        n.mag = '0;
      end else begin
        n.blank = 1'b0;
        n.dir   = cur.tgt;
        n.mag   = 12'(m);
      end
    end else if (m == 0) begin
      n.mag = '0;
    end else if (neg == cur.dir) begin
      n.mag = 12'(m);
    end else begin
      n.blank = 1'b1;
      n.tgt   = neg;
      n.mag   = '0;
    end
    return n;
  endfunction

  // {fwd, rev} expected at position pos (1..PER) of an output period.
  function automatic logic [1:0] legs(input plan_t p, input int pos);
    if (p.blank) return 2'b00;
`ifdef MTR_DRV_BRAKE_EN
    if (p.mag == 0) return 2'b11;
`endif
    if (pos > int'(p.mag)) return 2'b00;
    return p.dir ? 2'b01 : 2'b10;
  endfunction

  // Model: decisions at the last count, visible from the next count 1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt    <= 0;
      since   <= 0;
      pend[0] <= '0;
      pend[1] <= '0;
      act[0]  <= '0;
      act[1]  <= '0;
    end else begin
      if (ecnt == PER - 1) begin
        pend[0] <= decide(pend[0], bus.lft_spd, bus.mtr_en);
        pend[1] <= decide(pend[1], bus.rght_spd, bus.mtr_en);
      end
      if (ecnt == 0) begin
        act[0] <= pend[0];
        act[1] <= pend[1];
      end
      ecnt  <= (ecnt + 1) % PER;
      since <= since + 1;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic wait_pend();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (ecnt == 0 && since > 0) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL period_end_timeout t=%0t", $time);
    end
  endtask

  task automatic wait_cnt(input int c);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (ecnt == c) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt_timeout c=%0d t=%0t", c, $time);
    end
  endtask

  function automatic logic signed [11:0] rnd_spd();
    logic signed [11:0] v;
    case ($urandom_range(0, 6))
      0:       v = 12'sh000;
      1:       v = 12'sh800;
      2:       v = 12'sh7FF;
      3:       v = 12'sh001;
      4:       v = 12'shFFF;
      default: v = 12'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    bus.lft_spd  = 12'sh000;
    bus.rght_spd = 12'sh000;
    bus.mtr_en   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      acc[i]  = 0;
      last[i] = 0;
    end

    // Per-cycle compare of all outputs against the model.
    fork
      forever begin
        logic [4:0] got;
        logic [4:0] exp_v;
        logic [1:0] el;
        logic [1:0] er;
        int         pos;
        @(negedge clk);
        if (rst_n) begin
          pos = (ecnt == 0) ? PER : ecnt;
          if (since == 0) begin
            el = 2'b00;
            er = 2'b00;
          end else begin
            el = legs(act[0], pos);
            er = legs(act[1], pos);
          end
          exp_v = {el, er, (ecnt == 0 && since > 0)};
          got   = {bus.lft_fwd_pwm, bus.lft_rev_pwm, bus.rght_fwd_pwm,
                   bus.rght_rev_pwm, bus.prd_sync};
          checks++;
          if (got !== exp_v) begin
            errors++;
            $display("FAIL cycle_cmp cnt=%0d got=%b exp=%b t=%0t", ecnt, got, exp_v, $time);
          end
          acc[0] += int'(bus.lft_fwd_pwm);
          acc[1] += int'(bus.lft_rev_pwm);
          acc[2] += int'(bus.rght_fwd_pwm);
          acc[3] += int'(bus.rght_rev_pwm);
          if (ecnt == 0 && since > 0) begin
            for (int i = 0; i < 4; i++) begin
              last[i] = acc[i];
              acc[i]  = 0;
            end
          end
        end else begin
          for (int i = 0; i < 4; i++) acc[i] = 0;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_lft_fwd", int'(bus.lft_fwd_pwm), 0);
    chk("rst_prd_sync", int'(bus.prd_sync), 0);
    rst_n = 1'b1;

    // Forward 256 from the second period
    bus.lft_spd = 12'sh100;
    wait_pend();
    chk("p1_lft_fwd", last[0], BRK);
    wait_pend();
    chk("p2_lft_fwd", last[0], 256);
    chk("p2_lft_rev", last[1], 0);
    chk("model_pin_mag", int'(act[0].mag), 256);

    // Mid-period change takes effect only at the next period
    wait_cnt(1000);
    bus.lft_spd = 12'sh200;
    wait_pend();
    chk("mid_cur_lft_fwd", last[0], 256);
    wait_pend();
    chk("mid_nxt_lft_fwd", last[0], 512);

    // Reversal on left, saturation toward reverse on right
    bus.lft_spd  = 12'shF00;
    bus.rght_spd = 12'sh800;
    wait_pend();
    chk("rv_a_lft_fwd", last[0], 512);
    chk("rv_a_rght_rev", last[3], BRK);
    wait_pend();
    chk("rv_blank_lft_fwd", last[0], 0);
    chk("rv_blank_lft_rev", last[1], 0);
    chk("rv_blank_rght_rev", last[3], 0);
    wait_pend();
    chk("rv_lft_rev", last[1], 256);
    chk("rv_lft_fwd", last[0], 0);
    chk("sat_rght_rev", last[3], 2047);

    // Right to full forward
    bus.rght_spd = 12'sh7FF;
    wait_pend();
    chk("r2_old_rght_rev", last[3], 2047);
    wait_pend();
    chk("r2_blank_rght_fwd", last[2], 0);
    wait_pend();
    chk("max_rght_fwd", last[2], 2047);
    chk("max_rght_rev", last[3], 0);

    // Enable dropped mid-period, restored in the following period
    wait_cnt(700);
    bus.mtr_en = 1'b0;
    wait_pend();
    chk("en_cur_lft_rev", last[1], 256);
    chk("en_cur_rght_fwd", last[2], 2047);
    wait_cnt(100);
    bus.mtr_en = 1'b1;
    wait_pend();
    chk("en_off_lft_rev", last[1], BRK);
    chk("en_off_rght_fwd", last[2], BRK);
    wait_pend();
    chk("en_back_lft_rev", last[1], 256);
    chk("en_back_rght_fwd", last[2], 2047);

    // Asynchronous reset mid-period
    wait_cnt(400);
    bus.lft_spd = 12'sh7FF;
    wait_cnt(500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lft_fwd", int'(bus.lft_fwd_pwm), 0);
    chk("arst_lft_rev", int'(bus.lft_rev_pwm), 0);
    chk("arst_rght_fwd", int'(bus.rght_fwd_pwm), 0);
    chk("arst_rght_rev", int'(bus.rght_rev_pwm), 0);
    chk("arst_prd_sync", int'(bus.prd_sync), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    begin
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
        @(negedge clk);
        #1;
        n++;
        if (bus.prd_sync) seen = 1'b1;
      end
      chk("prd_first_after_rst", n, 2048);
    end
    chk("post_rst_p1_lft_fwd", last[0], BRK);
    wait_pend();
    chk("post_rst_fwd_no_blank", last[0], 2047);

    // Randomized commands at random points in the period
    repeat (15 * PER) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 499) == 0) bus.lft_spd = rnd_spd();
      if ($urandom_range(0, 499) == 0) bus.rght_spd = rnd_spd();
      if ($urandom_range(0, 799) == 0) bus.mtr_en = ($urandom_range(0, 3) != 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mtr_drv_pwm.md
Name: mtr_drv_pwm

Overview:
- Consumes the signed 12-bit wheel-speed commands lft_spd and rght_spd produced by the balance/steer math stage.
- Converts each command to sign-magnitude and drives one H-bridge per wheel with a PWM pair.
- Duty changes only at period boundaries, so each PWM period is glitch-free.
- On every direction reversal, inserts one full blanking period (both legs off) before driving the new direction.

Parameters:
- PWM_W, 11, counter width; period = 2^PWM_W clocks (default 2048).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- lft_spd  input  12  signed left-wheel speed command (two's complement)
- rght_spd  input  12  signed right-wheel speed command
- mtr_en  input  1  motor enable; low forces zero magnitude from the next period boundary
- lft_fwd_pwm  output  1  left bridge forward-leg drive
- lft_rev_pwm  output  1  left bridge reverse-leg drive
- rght_fwd_pwm  output  1  right bridge forward-leg drive
- rght_rev_pwm  output  1  right bridge reverse-leg drive
- prd_sync  output  1  one-cycle pulse in the last clock of each PWM period

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: all PWM outputs 0, prd_sync 0, counter 0, both channel FSMs in FWD with latched magnitude 0.
- Counter: free-running PWM_W-bit up-counter, wraps from 2^PWM_W-1 to 0.
  - prd_sync is registered; it is high exactly in the cycle where the counter reads 0 again after wrap, i.e. once per period.
- Boundary: the clock where the counter equals 2^PWM_W-1. On that edge each channel samples its speed input and mtr_en.
- Magnitude (PWM_W bits):
  - mag = |spd|, with saturation: -2048 (0x800) gives 2047.
  - mtr_en = 0 gives mag 0.
  - sgn = spd[11].
- Channel FSM states: FWD, REV, BLANK. Transitions, evaluated at the boundary only:
  - FWD/REV with mag == 0: stay in the same state; the zero command never causes a reversal.
  - FWD/REV with mag != 0 and sgn matching the state: stay, latch mag.
  - FWD/REV with mag != 0 and sgn opposite the state: go to BLANK, record the target direction, latched mag = 0.
  - BLANK: go to the target direction and latch the new sample's mag.
    - If that sample's sign opposes the target and mag != 0, go to BLANK again toward the new sign.
- Outputs (registered, one clock after the counter compare):
  - fwd_pwm = (state == FWD) and (cnt < mag_latched).
  - rev_pwm = (state == REV) and (cnt < mag_latched).
  - In BLANK, both outputs are 0.
  - A leg is high for exactly mag_latched clocks per period.
  - fwd_pwm and rev_pwm are never both 1; the optional feature below is the only exception.
- Input changes mid-period have no effect until the next boundary.
- Reset asserted mid-period: outputs drop to 0 immediately (asynchronous), counter restarts at 0 after release.
- Latency: an input sampled at boundary N appears on the PWM outputs in the first clock of period N+1, registered.

Optional Feature:
- Macro name: MTR_DRV_BRAKE_EN.
- Defined: in FWD or REV with mag_latched == 0, both fwd_pwm and rev_pwm are driven 1 for the whole period (dynamic brake).
  - BLANK periods still drive both outputs 0.
- Not defined: a zero magnitude drives both outputs 0 (coast).

Decomposition:
- Package mtr_drv_pkg:
  - PWM_W default.
  - Typedef enum for channel state {FWD, REV, BLANK}.
  - Constant MAG_MAX = 2^PWM_W-1.
- Sub-module mtr_drv_chan: one instance per wheel; contains the FSM, magnitude conversion, latch and compare.
- The top level holds the shared counter and prd_sync.

Test Plan:
- After reset, lft_spd = 0x100 held: from the 2nd period on, lft_fwd_pwm is high 256 clocks per 2048-clock period; lft_rev_pwm stays 0.
- lft_spd changes from 0x100 to 0xF00 (-256): one full period with both left outputs 0, then lft_rev_pwm high 256 clocks per period.
- rght_spd = 0x800: rght_rev_pwm high 2047 of 2048 clocks. rght_spd = 0x7FF: the same pattern on rght_fwd_pwm.
- lft_spd changes from 0x100 to 0x200 at counter = 1000: the current period keeps 256 high clocks; the next period has 512.
- mtr_en deasserted mid-period: the current period is unchanged; the following period has all outputs 0 and the state is unchanged. With MTR_DRV_BRAKE_EN, both legs of each channel are high instead.
- rst_n pulsed low at counter = 500 while driving: outputs are 0 asynchronously; prd_sync first pulses 2048 clocks after release; the state is FWD.
